// File: rtl/sha512_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sha512_hash_ctrl
// Brief   : Sequences one sha512_block through a multi-block SHA-512 hash and
//           owns the chaining value H and the final digest handshake.
// Rev     : 1.0
// ============================================================================

module sha512_hash_ctrl #(
    parameter logic [511:0] H_INIT = {64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
                                      64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
                                      64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
                                      64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179},
    parameter int           ROUNDS = 80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1023:0] s_block,
    input  logic          s_first,
    input  logic          s_last,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [511:0]  digest,
    output logic [511:0]  blk_H_in,
    output logic [1023:0] blk_M_in,
    output logic          blk_input_valid,
    input  logic [511:0]  blk_H_out,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [6:0] c_last_round = 7'(ROUNDS - 1);

    state_t          r_state;
    logic [511:0]    r_h;
    logic [1023:0]   r_m;
    logic [6:0]      r_rcnt;
    logic            r_last;
    logic            r_s_ready;
    logic            r_d_valid;
    logic            r_blk_iv;
    logic            r_busy;

    // H and M change only at accept, capture and digest handshake, so the
    // block sees a stable H_in for the whole compression.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_h       <= H_INIT;
            r_m       <= '0;
            r_rcnt    <= '0;
            r_last    <= 1'b0;
            r_s_ready <= 1'b1;
            r_d_valid <= 1'b0;
            r_blk_iv  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_valid && r_s_ready) begin
                        r_m       <= s_block;
                        r_last    <= s_last;
                        if (s_first) begin
                            r_h <= H_INIT;
                        end
                        r_state   <= S_LOAD;
                        r_s_ready <= 1'b0;
                        r_blk_iv  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_rcnt   <= '0;
                    r_blk_iv <= 1'b0;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    r_rcnt <= r_rcnt + 7'd1;
                    if (r_rcnt == c_last_round) begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_h <= blk_H_out;
                    if (r_last) begin
                        r_state   <= S_OUT;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (d_ready) begin
                        r_h       <= H_INIT;
                        r_state   <= S_IDLE;
                        r_d_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_s_ready <= 1'b1;
                    r_d_valid <= 1'b0;
                    r_blk_iv  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready         = r_s_ready;
    assign d_valid         = r_d_valid;
    assign blk_input_valid = r_blk_iv;
    assign busy            = r_busy;
    assign digest          = r_h;
    assign blk_H_in        = r_h;
    assign blk_M_in        = r_m;

endmodule

`default_nettype wire

// File: tb/tb_sha512_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha512_hash_ctrl
// Brief   : Self-checking bench for sha512_hash_ctrl with a behavioural
//           SHA-512 compression model standing in for sha512_block.
// Rev     : 1.0
// ============================================================================

module tb_sha512_hash_ctrl;

    localparam logic [511:0] c_H_INIT = {64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
                                         64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
                                         64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
                                         64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
    localparam logic [511:0] c_ABC_DIG = {64'hddaf35a193617aba, 64'hcc417349ae204131,
                                          64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                                          64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                          64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [511:0] c_TWO_DIG = {64'h8e959b75dae313da, 64'h8cf4f72814fc143f,
                                          64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
                                          64'h501d289e4900f7e4, 64'h331b99dec4b5433a,
                                          64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_first = 1'b0;
    logic          s_last = 1'b0;
    logic          d_ready = 1'b0;
    logic [1023:0] s_block = '0;
    logic [511:0]  blk_H_out = '0;
    logic          s_ready, d_valid, blk_input_valid, busy;
    logic [511:0]  digest, blk_H_in;
    logic [1023:0] blk_M_in;

    sha512_hash_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_block(s_block),
        .s_first(s_first), .s_last(s_last),
        .d_valid(d_valid), .d_ready(d_ready), .digest(digest),
        .blk_H_in(blk_H_in), .blk_M_in(blk_M_in),
        .blk_input_valid(blk_input_valid), .blk_H_out(blk_H_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SHA-512 reference (plain FIPS 180-4 arithmetic) -------
    logic [63:0] k_tab [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] m);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[1023 - 64*i -: 64];
        for (int i = 16; i < 80; i++)
            w[i] = (ror(w[i-2], 19) ^ ror(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
                 + (ror(w[i-15], 1) ^ ror(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[511 - 64*i -: 64];
        for (int i = 0; i < 80; i++) begin
            t1 = v[7] + (ror(v[4], 14) ^ ror(v[4], 18) ^ ror(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[i] + w[i];
            t2 = (ror(v[0], 28) ^ ror(v[0], 34) ^ ror(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) compress[511 - 64*i -: 64] = hin[511 - 64*i -: 64] + v[i];
    endfunction

    // Block index blk of the standard padding of msg.
    function automatic logic [1023:0] pad_block(input byte unsigned msg[$], input int blk);
        int          len   = msg.size();
        int          nblk  = (len + 17 + 127) / 128;
        int          tot   = nblk * 128;
        logic [63:0] lbits = 64'(len) * 64'd8;
        logic [7:0]  b;
        int          p;
        for (int i = 0; i < 128; i++) begin
            p = blk * 128 + i;
            if (p < len)           b = msg[p];
            else if (p == len)     b = 8'h80;
            else if (p >= tot - 8) b = 8'(lbits >> ((tot - 1 - p) * 8));
            else                   b = 8'h00;
            pad_block[1023 - 8*i -: 8] = b;
        end
    endfunction

    function automatic logic [1023:0] rand_block();
        for (int j = 0; j < 32; j++) rand_block[j*32 +: 32] = $urandom();
    endfunction

    // ---------------- sha512_block stand-in ---------------------------------
    // Result appears only in the capture cycle, so early or late capture is seen.
    int           mcnt = 99;
    logic [511:0] m_h, m_res;
    always @(negedge clk) begin
        if (blk_input_valid) begin
            m_h       = blk_H_in;
            m_res     = compress(blk_H_in, blk_M_in);
            mcnt      = 0;
            blk_H_out = {16{$urandom()}};
        end else if (mcnt < 81) begin
            mcnt++;
            if (mcnt == 81) begin
                blk_H_out = m_res;
                if (!rst) chk("h_in_stable", blk_H_in, m_h);
            end
        end
    end

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic          first;
        logic          last;
        logic [1023:0] block;
        logic [511:0]  exp;
    } vec_t;
    vec_t         vecs[$];
    logic [511:0] ref_h = c_H_INIT;

    function automatic void add_vec(input logic f, input logic l, input logic [1023:0] blk,
                                    input logic [511:0] known, input bit use_known);
        vec_t v;
        if (f) ref_h = c_H_INIT;
        ref_h   = compress(ref_h, blk);
        v.first = f;
        v.last  = l;
        v.block = blk;
        v.exp   = use_known ? known : ref_h;
        if (l) ref_h = c_H_INIT;
        vecs.push_back(v);
    endfunction

    // ---------------- handshake tasks ---------------------------------------
    task automatic send(input logic f, input logic l, input logic [1023:0] b);
        int n = 0;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("send_timeout", 0, 1);
            return;
        end
        s_valid = 1'b1; s_first = f; s_last = l; s_block = b;
        @(posedge clk);
        #1;
        acc     = cyc;
        s_valid = 1'b0;
        chk("accept_busy", 512'(busy), 1);
        chk("accept_ready_low", 512'(s_ready), 0);
        chk("load_strobe", 512'(blk_input_valid), 1);
    endtask

    task automatic wait_dvalid(input logic [511:0] exp, input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        chk({name, "_latency"}, 512'(cyc - acc), 82);
        chk(name, digest, exp);
    endtask

    task automatic wait_ready();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("ready_timeout", 0, 1);
        else       chk("ready_latency", 512'(cyc - acc), 82);
    endtask

    task automatic consume(input int delay);
        repeat (delay) @(negedge clk);
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        d_ready = 1'b0;
        chk("dv_drop", 512'(d_valid), 0);
        chk("idle_ready", 512'(s_ready), 1);
        chk("digest_reinit", digest, c_H_INIT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte unsigned abc[$];
        byte unsigned two[$];
        logic [1023:0] abc_b, two_b0, two_b1;
        bit dv_seen;
        int nb;
        logic f;

        abc = '{8'h61, 8'h62, 8'h63};
        for (int g = 0; g < 14; g++)
            for (int c = 0; c < 8; c++) two.push_back(8'(8'h61 + g + c));
        abc_b  = pad_block(abc, 0);
        two_b0 = pad_block(two, 0);
        two_b1 = pad_block(two, 1);

        add_vec(1, 1, abc_b, c_ABC_DIG, 1);
        add_vec(1, 0, two_b0, '0, 0);
        add_vec(0, 1, two_b1, c_TWO_DIG, 1);
        add_vec(1, 0, two_b0, '0, 0);           // abandoned by the restart below
        add_vec(1, 1, abc_b, c_ABC_DIG, 1);
        for (int m = 0; m < 5; m++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                f = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
                add_vec(f, b == nb - 1, rand_block(), '0, 0);
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_s_ready", 512'(s_ready), 1);
        chk("rst_d_valid", 512'(d_valid), 0);
        chk("rst_blk_iv", 512'(blk_input_valid), 0);
        chk("rst_busy", 512'(busy), 0);
        chk("rst_digest", digest, c_H_INIT);
        chk("rst_m_zero", 512'(blk_M_in === '0), 1);

        foreach (vecs[i]) begin
            send(vecs[i].first, vecs[i].last, vecs[i].block);
            if (vecs[i].last) begin
                wait_dvalid(vecs[i].exp, $sformatf("vec%0d_digest", i));
                consume($urandom_range(0, 3));
            end else begin
                wait_ready();
            end
        end

        // Backpressure: digest held, pending block refused
        send(1, 1, abc_b);
        wait_dvalid(c_ABC_DIG, "bp_digest");
        s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_block = rand_block();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_digest", digest, c_ABC_DIG);
            chk("bp_hold_dvalid", 512'(d_valid), 1);
            chk("bp_no_ready", 512'(s_ready), 0);
        end
        s_valid = 1'b0;
        consume(0);
        @(negedge clk);
        chk("bp_not_accepted", 512'(busy), 0);
        send(1, 1, abc_b);
        wait_dvalid(c_ABC_DIG, "bp_after_digest");
        consume(1);

        // Reset in the middle of RUN (rcnt = 40)
        send(1, 1, abc_b);
        while (cyc < acc + 41) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_ready", 512'(s_ready), 1);
        chk("mid_rst_busy", 512'(busy), 0);
        chk("mid_rst_dvalid", 512'(d_valid), 0);
        chk("mid_rst_digest", digest, c_H_INIT);
        dv_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (d_valid) dv_seen = 1;
        end
        chk("mid_rst_no_digest", 512'(dv_seen), 0);
        send(1, 1, abc_b);
        wait_dvalid(c_ABC_DIG, "after_rst_digest");
        consume(0);

        // Stray s_valid while busy is ignored
        send(1, 1, abc_b);
        repeat (70) begin
            @(negedge clk);
            s_valid = 1'($urandom_range(0, 1));
            s_first = 1'($urandom_range(0, 1));
            s_last  = 1'($urandom_range(0, 1));
            s_block = rand_block();
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("ign_m_hold", 512'(blk_M_in === abc_b), 1);
        chk("ign_busy", 512'(busy), 1);
        wait_dvalid(c_ABC_DIG, "ign_digest");
        consume(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
